// File: rtl/axi_line_master_pkg.sv
// Shared AXI4 constants, master FSM state type and line alignment helper
// for the cache-line burst initiator.
package axi_line_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } mst_state_e;

  // line_bytes must be a power of two
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned line_bytes);
    return addr & ~(line_bytes - 32'd1);
  endfunction

endpackage

// File: rtl/axi_line_master_if.sv
// Memory-side AXI4 bus between the line master and the SDRAM target
// (single-ID, 32-bit data).
interface axi_line_master_if #(
  parameter int unsigned ID_W = 4
);
  logic            arvalid;
  logic            arready;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;

  logic            rvalid;
  logic            rready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic [ID_W-1:0] rid;
  logic            rlast;

  logic            awvalid;
  logic            awready;
  logic [31:0]     awaddr;
  logic [ID_W-1:0] awid;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;

  logic            wvalid;
  logic            wready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;

  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );

endinterface

// File: rtl/axi_line_master.sv
// Moves one cache line per request as a single AXI4 INCR burst (AR/R or AW/W/B);
// one transaction outstanding, one-cycle completion pulse.
module axi_line_master
  import axi_line_master_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [31:0]             req_addr_i,
  input  logic [32*LINE_WORDS-1:0] req_wdata_i,
  output logic                    resp_valid_o,
  output logic [32*LINE_WORDS-1:0] resp_rdata_o,
  output logic                    resp_err_o,
  axi_line_master_if.master       m_axi
);

  localparam int unsigned      CNT_W     = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [ID_W-1:0]  ID        = ID_W'(AXI_ID);

  mst_state_e              state_q, state_d;
  logic [CNT_W-1:0]        beat_q;
  logic [31:0]             addr_q;
  logic [32*LINE_WORDS-1:0] line_q;
  logic                    err_q;
  logic                    accept;
  logic                    beat_last;
  logic                    r_end;

  assign req_ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign accept       = req_valid_i && req_ready_o;
  assign beat_last    = (beat_q == LAST_BEAT);
  // A read burst closes on whichever of RLAST or the final counted beat comes first
  assign r_end        = m_axi.rlast || beat_last;

  assign resp_valid_o = (state_q == ST_DONE);
  assign resp_rdata_o = line_q;
  assign resp_err_o   = err_q;

  assign m_axi.araddr  = addr_q;
  assign m_axi.arid    = ID;
  assign m_axi.arlen   = 8'(LINE_WORDS - 1);
  assign m_axi.arsize  = AXI_SIZE_4B;
  assign m_axi.arburst = AXI_BURST_INCR;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awid    = ID;
  assign m_axi.awlen   = 8'(LINE_WORDS - 1);
  assign m_axi.awsize  = AXI_SIZE_4B;
  assign m_axi.awburst = AXI_BURST_INCR;

  assign m_axi.wdata   = line_q[32*32'(beat_q) +: 32];
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wlast   = beat_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.bready  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = req_write_i ? ST_AW : ST_AR;
      ST_AR: begin
        m_axi.arvalid = 1'b1;
        if (m_axi.arready) state_d = ST_R;
      end
      ST_R: begin
        m_axi.rready = 1'b1;
        if (m_axi.rvalid && r_end) state_d = ST_DONE;
      end
      ST_AW: begin
        m_axi.awvalid = 1'b1;
        if (m_axi.awready) state_d = ST_W;
      end
      ST_W: begin
        m_axi.wvalid = 1'b1;
        if (m_axi.wready && beat_last) state_d = ST_B;
      end
      ST_B: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The line buffer is filled by R beats and drained by W beats
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
      addr_q <= '0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept) begin
          addr_q <= line_align(req_addr_i, LINE_WORDS * 4);
          err_q  <= 1'b0;
          beat_q <= '0;
          if (req_write_i) line_q <= req_wdata_i;
        end
        ST_R: if (m_axi.rvalid) begin
          line_q[32*32'(beat_q) +: 32] <= m_axi.rdata;
          if ((m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rid != ID) ||
              (m_axi.rlast != beat_last))
            err_q <= 1'b1;
          beat_q <= r_end ? '0 : beat_q + CNT_W'(1);
        end
        ST_W: if (m_axi.wready) begin
          beat_q <= beat_last ? '0 : beat_q + CNT_W'(1);
        end
        ST_B: if (m_axi.bvalid) begin
          if ((m_axi.bresp != AXI_RESP_OKAY) || (m_axi.bid != ID))
            err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master: a scripted AXI target, a transaction-level
// expectation model and a per-cycle compare process.
module tb_axi_line_master;
  import axi_line_master_pkg::*;

  localparam int unsigned LW  = 8;
  localparam int unsigned IDW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_write;
  logic [31:0]       req_addr;
  logic [32*LW-1:0]  req_wdata, resp_rdata;
  logic              resp_valid, resp_err;

  axi_line_master_if #(.ID_W(IDW)) bus ();

  axi_line_master #(.LINE_WORDS(LW), .ID_W(IDW), .AXI_ID(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // target configuration
  logic [31:0] rbase = '0;
  int          rerr_beat = -1;
  int          rlast_beat = LW - 1;
  int          aw_stall = 0;
  bit          wtoggle = 1'b0;
  logic [1:0]  bresp_cfg = AXI_RESP_OKAY;

  // target state
  bit r_pend = 0, aw_done = 0, b_pend = 0;
  int r_idx = 0, w_cnt = 0, w_total = 0, wlast_cnt = 0;

  // expectation model for the transaction in flight
  bit          exp_write = 0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_line [LW];
  bit          exp_mask [LW];
  bit          exp_err = 0;
  int          exp_lat = -1;

  bit          busy = 0;
  int          acc_cyc = 0, resp_cnt = 0, awv_cnt = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // scripted AXI target: sample handshakes at the edge, drive 1 time unit later
  initial forever begin
    @(posedge clk);
    if (rst) begin
      r_pend = 0; b_pend = 0; aw_done = 0; w_cnt = 0; r_idx = 0;
    end else begin
      if (bus.arvalid && bus.arready) begin r_pend = 1; r_idx = 0; end
      if (bus.rvalid && bus.rready) begin
        if (bus.rlast) r_pend = 0;
        r_idx++;
      end
      if (bus.awvalid && bus.awready) begin aw_done = 1; w_cnt = 0; end
      else if (bus.awvalid && aw_stall > 0) aw_stall--;
      if (bus.wvalid && bus.wready) begin
        w_cnt++; w_total++;
        if (bus.wlast) begin b_pend = 1; wlast_cnt++; end
      end
      if (bus.bvalid && bus.bready) begin b_pend = 0; aw_done = 0; w_cnt = 0; end
    end
    #1;
    bus.arready = 1'b1;
    bus.rvalid  = r_pend;
    bus.rdata   = rbase + 32'(r_idx);
    bus.rlast   = (r_idx == rlast_beat);
    bus.rresp   = (r_idx == rerr_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    bus.rid     = '0;
    bus.awready = (aw_stall == 0);
    bus.wready  = wtoggle ? !bus.wready : 1'b1;
    bus.bvalid  = b_pend;
    bus.bresp   = bresp_cfg;
    bus.bid     = '0;
  end

  // per-cycle compare against the expectation model
  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      if (rst) begin
        busy = 0;
        check_eq("req_ready_in_reset", 64'(req_ready), 64'(0));
      end else begin
        check_eq("req_ready", 64'(req_ready), 64'(!busy));
        if (!busy) begin
          check_eq("arvalid_idle", 64'(bus.arvalid), 64'(0));
          check_eq("awvalid_idle", 64'(bus.awvalid), 64'(0));
          check_eq("wvalid_idle", 64'(bus.wvalid), 64'(0));
          check_eq("resp_valid_idle", 64'(resp_valid), 64'(0));
        end
        if (bus.arvalid) begin
          last_araddr = bus.araddr;
          check_eq("ar_dir", 64'(exp_write), 64'(0));
          check_eq("araddr", 64'(bus.araddr), 64'(exp_addr));
          check_eq("arlen", 64'(bus.arlen), 64'(LW - 1));
          check_eq("arsize", 64'(bus.arsize), 64'(2));
          check_eq("arburst", 64'(bus.arburst), 64'(1));
          check_eq("arid", 64'(bus.arid), 64'(0));
        end
        if (bus.awvalid) begin
          awv_cnt++;
          last_awaddr = bus.awaddr;
          check_eq("aw_dir", 64'(exp_write), 64'(1));
          check_eq("awaddr", 64'(bus.awaddr), 64'(exp_addr));
          check_eq("awlen", 64'(bus.awlen), 64'(LW - 1));
          check_eq("awsize", 64'(bus.awsize), 64'(2));
          check_eq("awburst", 64'(bus.awburst), 64'(1));
          check_eq("awid", 64'(bus.awid), 64'(0));
        end
        if (bus.wvalid) begin
          check_eq("w_after_aw", 64'(aw_done), 64'(1));
          check_eq("w_beat_in_range", 64'(w_cnt < LW), 64'(1));
          if (w_cnt < LW) check_eq("wdata", 64'(bus.wdata), 64'(exp_line[w_cnt]));
          check_eq("wlast", 64'(bus.wlast), 64'(w_cnt == LW - 1));
          check_eq("wstrb", 64'(bus.wstrb), 64'(4'hF));
        end
        if (resp_valid && busy) begin
          resp_cnt++;
          check_eq("resp_err", 64'(resp_err), 64'(exp_err));
          if (!exp_write)
            for (int i = 0; i < LW; i++)
              if (exp_mask[i])
                check_eq("resp_rdata_word", 64'(resp_rdata[32*i +: 32]), 64'(exp_line[i]));
          if (exp_lat >= 0) check_eq("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
          busy = 0;
        end
        if (req_valid && req_ready) begin
          busy = 1;
          acc_cyc = cyc;
        end
      end
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [32*LW-1:0] d);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int max_cyc);
    int c0;
    int k;
    c0 = resp_cnt;
    k = 0;
    while (resp_cnt == c0 && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    check_eq("resp_arrived", 64'(resp_cnt != c0), 64'(1));
    #1;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] base,
                         input int errb, input int lastb);
    rbase = base; rerr_beat = errb; rlast_beat = lastb;
    exp_write = 0;
    exp_addr  = a - (a % (LW * 4));
    for (int i = 0; i < LW; i++) begin
      exp_line[i] = base + 32'(i);
      exp_mask[i] = (i <= lastb);
    end
    exp_err = (errb >= 0 && errb <= lastb) || (lastb != LW - 1);
    exp_lat = 2 + lastb + 1;
    issue(1'b0, a, '0);
    wait_resp(100);
  endtask

  task automatic prep_write(input logic [31:0] a, input logic [32*LW-1:0] d, input logic [1:0] br);
    bresp_cfg = br;
    exp_write = 1;
    exp_addr  = a - (a % (LW * 4));
    for (int i = 0; i < LW; i++) exp_line[i] = d[32*i +: 32];
    exp_err = (br != AXI_RESP_OKAY);
    exp_lat = (wtoggle || aw_stall > 0) ? -1 : 3 + LW;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [32*LW-1:0] d, input logic [1:0] br);
    prep_write(a, d, br);
    issue(1'b1, a, d);
    wait_resp(100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [32*LW-1:0] line;
  int               c0, k, wt0, wl0;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_reset_ready", 64'(req_ready), 64'(1));
    check_eq("post_reset_err", 64'(resp_err), 64'(0));
    check_eq("post_reset_valid", 64'(resp_valid), 64'(0));
    check_eq("post_reset_arvalid", 64'(bus.arvalid), 64'(0));
    @(posedge clk); #1;

    // zero-wait line read from an unaligned address
    do_read(32'h0000_1234, 32'hA0, -1, LW - 1);
    check_eq("t1_araddr_literal", 64'(last_araddr), 64'(32'h0000_1220));
    check_eq("t1_word0_literal", 64'(resp_rdata[31:0]), 64'(32'hA0));
    check_eq("t1_word7_literal", 64'(resp_rdata[255:224]), 64'(32'hA7));
    check_eq("t1_err_literal", 64'(resp_err), 64'(0));

    // write with WREADY toggling every cycle
    for (int i = 0; i < LW; i++) line[32*i +: 32] = 32'h10 + 32'(i);
    wtoggle = 1'b1;
    wt0 = w_total; wl0 = wlast_cnt;
    do_write(32'h2000_0048, line, AXI_RESP_OKAY);
    wtoggle = 1'b0;
    check_eq("t2_beats_literal", 64'(w_total - wt0), 64'(8));
    check_eq("t2_wlast_once_literal", 64'(wlast_cnt - wl0), 64'(1));
    check_eq("t2_awaddr_literal", 64'(last_awaddr), 64'(32'h2000_0040));

    // AWREADY held low for 20 cycles
    for (int i = 0; i < LW; i++) line[32*i +: 32] = 32'h5500_0000 + 32'(i * 3);
    aw_stall = 20;
    awv_cnt = 0;
    do_write(32'h3000_0005, line, AXI_RESP_OKAY);
    check_eq("t3_awvalid_cycles_literal", 64'(awv_cnt), 64'(21));
    check_eq("t3_err_literal", 64'(resp_err), 64'(0));

    // SLVERR on beat 3, then a clean read must clear the error
    do_read(32'h4000_0100, 32'hB0, 3, LW - 1);
    check_eq("t4_err_literal", 64'(resp_err), 64'(1));
    check_eq("t4_word7_literal", 64'(resp_rdata[255:224]), 64'(32'hB7));
    do_read(32'h4000_0120, 32'hC0, -1, LW - 1);
    check_eq("t4_clean_err_literal", 64'(resp_err), 64'(0));

    // early RLAST after six beats
    do_read(32'h5000_001C, 32'hD0, -1, 5);
    check_eq("t5_err_literal", 64'(resp_err), 64'(1));
    check_eq("t5_word5_literal", 64'(resp_rdata[191:160]), 64'(32'hD5));

    // DECERR write, zero-wait
    for (int i = 0; i < LW; i++) line[32*i +: 32] = 32'hE0 + 32'(i);
    do_write(32'h6000_0000, line, AXI_RESP_DECERR);
    check_eq("t5_decerr_literal", 64'(resp_err), 64'(1));

    // reset during W beat 4
    for (int i = 0; i < LW; i++) line[32*i +: 32] = 32'hF0 + 32'(i);
    prep_write(32'h7000_0020, line, AXI_RESP_OKAY);
    issue(1'b1, 32'h7000_0020, line);
    k = 0;
    while (w_cnt < 4 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check_eq("t6_reached_beat4", 64'(w_cnt), 64'(4));
    #1 rst = 1'b1;
    c0 = resp_cnt;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("t6_wvalid_dropped", 64'(bus.wvalid), 64'(0));
    check_eq("t6_ready_after_reset", 64'(req_ready), 64'(1));
    check_eq("t6_no_resp_pulse_now", 64'(resp_valid), 64'(0));
    repeat (5) @(posedge clk);
    check_eq("t6_no_resp_pulse_later", 64'(resp_cnt), 64'(c0));
    #1;

    // recovery read after reset
    do_read(32'h0000_0000, 32'h1000, -1, LW - 1);
    check_eq("t7_word3_literal", 64'(resp_rdata[127:96]), 64'(32'h1003));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
